// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush controller for the 5-stage pipeline: load-use bubbles, branch and
// jump redirects, memory wait with timeout, and exception entry/drain.
module pipeline_hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int EXC_DRAIN  = 2,
  parameter int MEM_TMO    = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_br_taken,
  input  logic       id_jump,
  input  logic       id_illop,
  input  logic       id_xadr,
  input  logic       mem_busy,
  output logic       pc_hold,
  output logic       ifid_hold,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       pipe_freeze,
  output logic [1:0] pc_sel,
  output logic       epc_we,
  output logic       busy_err
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, EXC} state_t;

  localparam logic [3:0] LU_INIT  = 4'(LU_BUBBLES - 1);
  localparam logic [3:0] EXC_INIT = 4'(EXC_DRAIN - 1);
  localparam logic [3:0] TMO      = 4'(MEM_TMO);
  localparam bit         LU_MULTI = (LU_BUBBLES > 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       lu_hit, exc_req, tmo_hit;

  assign lu_hit  = ex_memread && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_use_rt && (ex_rt == id_rt)));
  assign exc_req = id_illop || id_xadr;
  // A memory stall that outlives the budget is turned into a bus-error exception.
  assign tmo_hit = (state == MEM_WAIT) && mem_busy && (cnt == TMO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= 4'd0;
      busy_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (tmo_hit) busy_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          if (state == RUN) begin
            state_nxt = MEM_WAIT;
            cnt_nxt   = 4'd1;
          end else if (tmo_hit) begin
            state_nxt = EXC;
            cnt_nxt   = EXC_INIT;
          end else if (cnt != 4'hF) begin
            cnt_nxt = cnt + 4'd1;
          end
        end else if (ex_br_taken) begin
          state_nxt = RUN;
        end else if (exc_req) begin
          state_nxt = EXC;
          cnt_nxt   = EXC_INIT;
        end else if (lu_hit && LU_MULTI) begin
          state_nxt = LU_STALL;
          cnt_nxt   = LU_INIT;
        end else begin
          state_nxt = RUN;
        end
      end
      LU_STALL: begin
        if (mem_busy) begin
          state_nxt = MEM_WAIT;
          cnt_nxt   = 4'd1;
        end else if (cnt <= 4'd1) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      EXC: begin
        if (cnt == 4'd0) state_nxt = RUN;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    pc_sel      = 2'd0;
    epc_we      = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state)
        RUN, MEM_WAIT: begin
          if (tmo_hit) begin
            pc_sel     = 2'd3;
            epc_we     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (mem_busy) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            pipe_freeze = 1'b1;
          end else if (ex_br_taken) begin
            pc_sel     = 2'd1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (exc_req) begin
            pc_sel     = 2'd3;
            epc_we     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu_hit) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
          end else if (id_jump) begin
            pc_sel     = 2'd2;
            ifid_flush = 1'b1;
          end
        end
        LU_STALL: begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          if (mem_busy) pipe_freeze = 1'b1;
          else          idex_flush  = 1'b1;
        end
        EXC: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        default: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
      endcase
    end
  end

endmodule
